// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer arbiter: default widths, the host write
// entry layout and the bank-swap state encoding.
package fb_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLIP    = 2'd2
  } swap_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Generic synchronous FIFO for buffered host writes; the entry type is a
// type parameter so the top can size address/data to its own widths.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter type T     = wr_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and occupancy are control.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer arbiter: display reads (front bank) always win over
// buffered host writes (back bank); bank swaps are vsync-synchronised.
// Optional statistics outputs are enabled with `define FB_ARB_STATS_EN.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              vsync,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_swap,
  output logic              swap_done,
  output logic              front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [7:0]        stat_defer_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  swap_state_e       r_state, w_state_nxt;
  entry_t            w_din, w_dout;
  logic              w_push, w_pop, w_full, w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_swap_pending, w_wr_now, w_flip_ok;
  logic              r_wr_prev, r_front_bank;
  logic              r_mem_en, r_mem_we, r_mem_bank;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [MEM_LAT:0]  r_rd_vld_p;
  logic [DATA_W-1:0] r_rdata_hold;

  assign w_din      = '{addr: host_addr, data: host_wdata};
  assign host_ready = !w_full && !w_swap_pending;
  assign w_push     = host_valid && host_ready;
  assign w_pop      = !disp_req && !w_empty;

  fb_wr_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // A flip must not race a write still landing in the old back bank.
  assign w_wr_now  = r_mem_en && r_mem_we;
  assign w_flip_ok = vsync && (w_count == '0) && !w_wr_now && !r_wr_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (host_swap) w_state_nxt = PENDING;
      PENDING: if (w_flip_ok) w_state_nxt = FLIP;
      FLIP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_swap_pending = (r_state != IDLE);
    swap_done      = (r_state == FLIP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front_bank <= 1'b0;
      r_wr_prev    <= 1'b0;
    end else begin
      if (w_state_nxt == FLIP) r_front_bank <= ~r_front_bank;
      r_wr_prev <= w_wr_now;
    end
  end

  // Issue stage: request sampled at t drives the memory bus at t+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_bank  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (disp_req) begin
      r_mem_en   <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_bank <= r_front_bank;
      r_mem_addr <= disp_addr;
    end else if (!w_empty) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_bank  <= ~r_front_bank;
      r_mem_addr  <= w_dout.addr;
      r_mem_wdata <= w_dout.data;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // Return stage: read valid tracks the request through the memory latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld_p   <= '0;
      r_rdata_hold <= '0;
    end else begin
      r_rd_vld_p <= {r_rd_vld_p[MEM_LAT-1:0], disp_req};
      if (disp_rvalid) r_rdata_hold <= mem_rdata;
    end
  end

  assign disp_rvalid = r_rd_vld_p[MEM_LAT];
  assign disp_rdata  = disp_rvalid ? mem_rdata : r_rdata_hold;
  assign front_bank  = r_front_bank;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_bank    = r_mem_bank;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stat_wr;
  logic [7:0]  r_stat_defer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_wr    <= '0;
      r_stat_defer <= '0;
    end else begin
      if (w_pop && (r_stat_wr != '1)) r_stat_wr <= r_stat_wr + 1'b1;
      if ((r_state == PENDING) && vsync && !w_flip_ok && (r_stat_defer != '1))
        r_stat_defer <= r_stat_defer + 1'b1;
    end
  end

  assign stat_wr_cnt    = r_stat_wr;
  assign stat_defer_cnt = r_stat_defer;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter with a behavioural single-port memory
// (MEM_LAT = 1); reads only touch addresses the host never writes.
module tb_fb_mem_arbiter;

  logic       clk, rst;
  logic       disp_req, disp_rvalid, vsync, host_valid, host_ready, host_swap;
  logic       swap_done, front_bank, mem_en, mem_we, mem_bank;
  logic [8:0] disp_addr, host_addr, mem_addr;
  logic [7:0] disp_rdata, host_wdata, mem_wdata, mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [7:0]  stat_defer_cnt;
`endif

  fb_mem_arbiter #(.ADDR_W(9), .DATA_W(8), .FIFO_DEPTH(4), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .vsync(vsync),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_swap(host_swap), .swap_done(swap_done), .front_bank(front_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_defer_cnt(stat_defer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Bench-side model state
  int   exp_cnt = 0;
  int   exp_wr_total = 0;
  logic exp_pend = 1'b0;
  logic exp_front = 1'b0;
  logic last_acc = 1'b0;

  logic [9:0]  q_rd_req[$];
  logic [7:0]  q_rdata[$];
  logic [17:0] q_wr[$];

  logic [7:0] tb_mem [2][512];

  function automatic logic [7:0] pat(input logic b, input logic [8:0] a);
    return a[7:0] ^ {b, a[8], 6'h15};
  endfunction

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++)
        tb_mem[b][a] = pat(b[0], a[8:0]);
  end

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_bank][mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_bank][mem_addr];
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT produces something.
  always @(negedge clk) begin
    logic [9:0]  e_rd;
    logic [7:0]  e_dat;
    logic [17:0] e_wr;
    if (!rst) begin
      if (mem_en && !mem_we) begin
        n_vec++;
        if (q_rd_req.size() == 0) begin
          n_miss++;
          $display("FAIL rd_issue: unexpected read bank=%0d addr=%h", mem_bank, mem_addr);
        end else begin
          e_rd = q_rd_req.pop_front();
          if ({mem_bank, mem_addr} !== e_rd) begin
            n_miss++;
            $display("FAIL rd_issue: got bank/addr %h, want %h", {mem_bank, mem_addr}, e_rd);
          end
        end
      end
      if (mem_en && mem_we) begin
        n_vec++;
        if (q_wr.size() == 0) begin
          n_miss++;
          $display("FAIL wr_issue: unexpected write bank=%0d addr=%h", mem_bank, mem_addr);
        end else begin
          e_wr = q_wr.pop_front();
          if ({mem_bank, mem_addr, mem_wdata} !== e_wr) begin
            n_miss++;
            $display("FAIL wr_issue: got bank/addr/data %h, want %h",
                     {mem_bank, mem_addr, mem_wdata}, e_wr);
          end
        end
      end
      if (disp_rvalid) begin
        n_vec++;
        if (q_rdata.size() == 0) begin
          n_miss++;
          $display("FAIL rdata: unexpected rvalid data=%h", disp_rdata);
        end else begin
          e_dat = q_rdata.pop_front();
          if (disp_rdata !== e_dat) begin
            n_miss++;
            $display("FAIL rdata: got %h, want %h", disp_rdata, e_dat);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: drive inputs, check host_ready, push expectations, advance.
  task automatic cycle(input logic req, input logic [8:0] raddr, input logic hv,
                       input logic [8:0] haddr, input logic [7:0] hdata);
    logic exp_rdy, pop;
    disp_req = req; disp_addr = raddr;
    host_valid = hv; host_addr = haddr; host_wdata = hdata;
    exp_rdy = (exp_cnt < 4) && !exp_pend;
    n_vec++;
    if (host_ready !== exp_rdy) begin
      n_miss++;
      $display("FAIL host_ready: got %b, want %b (t=%0t)", host_ready, exp_rdy, $time);
    end
    last_acc = hv && exp_rdy;
    pop = !req && (exp_cnt > 0);
    if (req) begin
      q_rd_req.push_back({exp_front, raddr});
      q_rdata.push_back(pat(exp_front, raddr));
    end
    if (last_acc) q_wr.push_back({~exp_front, haddr, hdata});
    exp_cnt = exp_cnt + int'(last_acc) - int'(pop);
    if (pop) exp_wr_total++;
    tick();
    disp_req = 1'b0; host_valid = 1'b0; vsync = 1'b0; host_swap = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_en, mem_we, mem_bank, mem_addr, mem_wdata} !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_mem: got %h, want 0", {mem_en, mem_we, mem_bank, mem_addr, mem_wdata});
    end
    n_vec++;
    if ({disp_rvalid, disp_rdata, swap_done, front_bank, host_ready} !== 12'h001) begin
      n_miss++;
      $display("FAIL reset_ctl: got %h, want 001",
               {disp_rvalid, disp_rdata, swap_done, front_bank, host_ready});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (mem_en !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_idle: mem_en got %b, want 0", mem_en);
    end
  endtask

  task automatic test_reads();
    cycle(1'b1, 9'h005, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({mem_en, mem_we, mem_bank, mem_addr} !== {3'b100, 9'h005}) begin
      n_miss++;
      $display("FAIL read_issue: got %h, want %h", {mem_en, mem_we, mem_bank, mem_addr}, {3'b100, 9'h005});
    end
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({disp_rvalid, disp_rdata} !== {1'b1, pat(1'b0, 9'h005)}) begin
      n_miss++;
      $display("FAIL read_latency: got %h, want %h", {disp_rvalid, disp_rdata}, {1'b1, pat(1'b0, 9'h005)});
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 9'h100 + 9'(i), 1'b0, 9'h0, 8'h0);
    repeat (3) cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({disp_rvalid, disp_rdata} !== {1'b0, pat(1'b0, 9'h103)}) begin
      n_miss++;
      $display("FAIL rdata_hold: got %h, want %h", {disp_rvalid, disp_rdata}, {1'b0, pat(1'b0, 9'h103)});
    end
  endtask

  task automatic test_write_buffering();
    int idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 9'h180 + 9'(c), 1'b1, 9'h010 + 9'(idx), 8'hA0 + 8'(idx));
      if (last_acc) idx++;
    end
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 9'h0, idx < 5, 9'h010 + 9'(idx), 8'hA0 + 8'(idx));
      if (last_acc) idx++;
    end
    n_vec++;
    if (q_wr.size() != 0) begin
      n_miss++;
      $display("FAIL wr_drain: %0d writes outstanding, want 0", q_wr.size());
    end
  endtask

  task automatic test_priority_tie();
    cycle(1'b1, 9'h1c0, 1'b1, 9'h040, 8'h5A);
    cycle(1'b1, 9'h1c1, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 9'h1c1}) begin
      n_miss++;
      $display("FAIL tie_read: got %h, want %h", {mem_en, mem_we, mem_addr}, {2'b10, 9'h1c1});
    end
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({mem_en, mem_we, mem_bank, mem_addr, mem_wdata} !== {3'b111, 9'h040, 8'h5A}) begin
      n_miss++;
      $display("FAIL tie_write: got %h, want %h",
               {mem_en, mem_we, mem_bank, mem_addr, mem_wdata}, {3'b111, 9'h040, 8'h5A});
    end
    repeat (3) cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
  endtask

  task automatic test_swap();
    host_swap = 1'b1;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    exp_pend = 1'b1;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    vsync = 1'b1;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({swap_done, front_bank} !== 2'b11) begin
      n_miss++;
      $display("FAIL swap_flip: swap_done/front got %b, want 11", {swap_done, front_bank});
    end
    exp_front = 1'b1;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({swap_done, front_bank} !== 2'b01) begin
      n_miss++;
      $display("FAIL swap_pulse: swap_done/front got %b, want 01", {swap_done, front_bank});
    end
    exp_pend = 1'b0;
    cycle(1'b0, 9'h0, 1'b1, 9'h020, 8'hC3);
    repeat (3) cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
  endtask

  task automatic test_deferred_swap();
    cycle(1'b1, 9'h1a0, 1'b1, 9'h030, 8'h11);
    cycle(1'b1, 9'h1a1, 1'b1, 9'h031, 8'h22);
    host_swap = 1'b1;
    cycle(1'b1, 9'h1a2, 1'b0, 9'h0, 8'h0);
    exp_pend = 1'b1;
    cycle(1'b1, 9'h1a3, 1'b0, 9'h0, 8'h0);
    vsync = 1'b1;
    cycle(1'b1, 9'h1a4, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({swap_done, front_bank} !== 2'b01) begin
      n_miss++;
      $display("FAIL defer_noflip: swap_done/front got %b, want 01", {swap_done, front_bank});
    end
`ifdef FB_ARB_STATS_EN
    n_vec++;
    if (stat_defer_cnt !== 8'd1) begin
      n_miss++;
      $display("FAIL stat_defer: got %0d, want 1", stat_defer_cnt);
    end
`endif
    repeat (4) cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    vsync = 1'b1;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({swap_done, front_bank} !== 2'b10) begin
      n_miss++;
      $display("FAIL defer_flip: swap_done/front got %b, want 10", {swap_done, front_bank});
    end
    exp_front = 1'b0;
    cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    exp_pend = 1'b0;
`ifdef FB_ARB_STATS_EN
    n_vec++;
    if (stat_wr_cnt !== 16'(exp_wr_total)) begin
      n_miss++;
      $display("FAIL stat_wr: got %0d, want %0d", stat_wr_cnt, exp_wr_total);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    cycle(1'b1, 9'h1d0, 1'b1, 9'h050, 8'h77);
    cycle(1'b1, 9'h1d1, 1'b1, 9'h051, 8'h78);
    cycle(1'b1, 9'h1d2, 1'b1, 9'h052, 8'h79);
    #1 rst = 1'b1;
    q_rd_req.delete(); q_rdata.delete(); q_wr.delete();
    exp_cnt = 0; exp_pend = 1'b0; exp_front = 1'b0; exp_wr_total = 0;
    #1;
    n_vec++;
    if ({mem_en, mem_we, mem_bank, mem_addr, mem_wdata, disp_rvalid, disp_rdata,
         swap_done, front_bank, host_ready} !== 32'h0000_0001) begin
      n_miss++;
      $display("FAIL reset_async: got %h, want 00000001",
               {mem_en, mem_we, mem_bank, mem_addr, mem_wdata, disp_rvalid, disp_rdata,
                swap_done, front_bank, host_ready});
    end
`ifdef FB_ARB_STATS_EN
    n_vec++;
    if ({stat_wr_cnt, stat_defer_cnt} !== 24'h0) begin
      n_miss++;
      $display("FAIL reset_stats: got %h, want 0", {stat_wr_cnt, stat_defer_cnt});
    end
`endif
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
      n_vec++;
      if ({mem_en, disp_rvalid} !== 2'b00) begin
        n_miss++;
        $display("FAIL reset_quiet: mem_en/rvalid got %b, want 00", {mem_en, disp_rvalid});
      end
    end
    cycle(1'b1, 9'h1e0, 1'b0, 9'h0, 8'h0);
    n_vec++;
    if ({mem_en, mem_we, mem_bank, mem_addr} !== {3'b100, 9'h1e0}) begin
      n_miss++;
      $display("FAIL reset_resume: got %h, want %h", {mem_en, mem_we, mem_bank, mem_addr}, {3'b100, 9'h1e0});
    end
    repeat (3) cycle(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
  endtask

  task automatic test_final_drain();
    n_vec++;
    if ((q_rd_req.size() + q_rdata.size() + q_wr.size()) != 0) begin
      n_miss++;
      $display("FAIL final_drain: rd=%0d rdata=%0d wr=%0d outstanding, want 0",
               q_rd_req.size(), q_rdata.size(), q_wr.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    disp_req = 1'b0; disp_addr = '0; vsync = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_wdata = '0; host_swap = 1'b0;
    test_reset();
    test_reads();
    test_write_buffering();
    test_priority_tie();
    test_swap();
    test_deferred_swap();
    test_reset_mid_burst();
    test_final_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares one single-port framebuffer memory between the display scanout path (pixel reads, hard real-time) and a host write port (buffered, best-effort).
- Manages double buffering: the display reads the front bank and the host writes the back bank.
- Bank swaps are vsync-synchronised.
- Sits between the video timing/pixel fetch logic and the external framebuffer memory interface (bank + address + data) on the FPGA board top.

Parameters:
- ADDR_W, 9, pixel word address width within one bank
- DATA_W, 8, memory data word width
- FIFO_DEPTH, 4, host write FIFO entries (power of two, >=2)
- MEM_LAT, 1, memory read latency in cycles from registered mem_en to valid mem_rdata (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_W  display read address (front bank implied)
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- vsync  in  1  single-cycle pulse at start of vertical blanking
- host_valid  in  1  host write offered
- host_ready  out  1  host write accepted when valid&&ready
- host_addr  in  ADDR_W  host write address (back bank implied)
- host_wdata  in  DATA_W  host write data
- host_swap  in  1  single-cycle swap request
- swap_done  out  1  one-cycle pulse when front bank flips
- front_bank  out  1  current display bank
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  write enable (registered)
- mem_bank  out  1  bank select (registered)
- mem_addr  out  ADDR_W  address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- mem_rdata  in  DATA_W  read data, MEM_LAT cycles after mem_en

Behaviour:
- Reset values: all mem_* 0, disp_rvalid 0, disp_rdata 0, swap_done 0, front_bank 0, host_ready 1. FIFO is empty, swap_pending is 0 and the read-valid pipeline is cleared. Reset asserted mid-operation drops in-flight writes and reads with no partial completion.
- Arbitration per cycle, fixed priority:
  - disp_req=1: issue read {front_bank, disp_addr}.
  - Otherwise, if the FIFO is not empty: pop and issue write {~front_bank, addr, data}.
  - Otherwise: mem_en=0.
- The display is never stalled.
- Read latency: disp_req at cycle t → mem_en at t+1 → disp_rvalid/disp_rdata at t+1+MEM_LAT. The rvalid shift pipeline is MEM_LAT+1 deep. disp_rdata holds its last value when rvalid=0.
- FIFO:
  - host_ready = !full && !swap_pending.
  - Push on valid&&ready.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - No bypass: a word pushed at t is issued at t+1 at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
- Swap FSM:
  - States: IDLE, PENDING, FLIP.
  - IDLE --host_swap--> PENDING. host_swap while PENDING or FLIP is ignored.
  - PENDING: on a vsync pulse with FIFO empty and no write issued in the current or previous cycle, go to FLIP. If those conditions fail at vsync, the swap is deferred to the next vsync; vsync is not latched.
  - FLIP: front_bank toggles and swap_done=1 for exactly one cycle, then return to IDLE. host_ready re-asserts in the IDLE cycle.
  - A display read issued in the FLIP cycle uses the new front_bank, which is registered before the mem issue mux.
- Simultaneous vsync and host_swap in IDLE: go to PENDING only; no flip on that vsync.

Optional Feature:
- Macro FB_ARB_STATS_EN. When defined, adds two outputs:
  - stat_wr_cnt [15:0]: saturating count of writes issued to memory.
  - stat_defer_cnt [7:0]: saturating count of vsyncs seen in PENDING that did not flip.
- Both counters reset to 0 on rst.
- When undefined, the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Package fb_arb_pkg holds:
  - default ADDR_W/DATA_W localparams
  - typedef wr_entry_t (struct: addr, data)
  - typedef swap_state_e (IDLE, PENDING, FLIP)
- Sub-module fb_wr_fifo: a generic synchronous FIFO of wr_entry_t with push/pop/full/empty/count, instantiated once.

Test Plan:
- Reads only: disp_req=1 with disp_addr=0x005 at t, front_bank=0 → mem_en=1, mem_we=0, mem_bank=0, mem_addr=0x005 at t+1; disp_rvalid=1 with mem_rdata at t+2 (MEM_LAT=1).
- Write buffering: 5 host writes to addr 0x010..0x014 while disp_req=1 continuously → host_ready drops after 4 pushes. disp_req then low for 5 cycles → 4 writes issued in order with mem_bank=1 and mem_we=1, then the 5th write accepted and issued.
- Swap: host_swap, FIFO empty, then vsync → front_bank 0→1 and swap_done pulse 1 cycle after vsync. A subsequent host write lands with mem_bank=0.
- Deferred swap: host_swap with 2 entries queued and disp_req held high through the first vsync → no flip (stat_defer_cnt=1 if enabled), host_ready=0. FIFO drains, then the second vsync → flip.
- Reset mid-burst: assert rst with 3 FIFO entries and rvalid in flight → all outputs at reset values immediately; no mem_en after release until a new request arrives.
- Priority tie: disp_req=1 and FIFO non-empty in the same cycle → read issued and FIFO count unchanged; the write issues on the first cycle with disp_req=0.
